axis_rr_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares one NoC injection port (one axis_in_* endpoint of the axis_mesh) between NUM_REQ AXI-Stream masters, e.g. num_gen and adder tiles co-located on one router.
- A grant is locked from the first beat until the TLAST beat, so packets are never interleaved in the mesh.
- Output goes through a 2-entry skid register slice, so every output is registered.

---
 rtl/axis_rr_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_REQ AXI-Stream masters share one injection port.
// A grant is held from the first beat to TLAST; beats leave through a 2-entry skid slice.
module axis_rr_arbiter #(
    parameter int TDATAW  = 32,
    parameter int TDESTW  = 4,
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [NUM_REQ-1:0]         AXIS_S_TVALID,
    output logic [NUM_REQ-1:0]         AXIS_S_TREADY,
    input  logic [NUM_REQ*TDATAW-1:0]  AXIS_S_TDATA,
    input  logic [NUM_REQ-1:0]         AXIS_S_TLAST,
    input  logic [NUM_REQ*TDESTW-1:0]  AXIS_S_TDEST,
    output logic                       AXIS_M_TVALID,
    input  logic                       AXIS_M_TREADY,
    output logic [TDATAW-1:0]          AXIS_M_TDATA,
    output logic                       AXIS_M_TLAST,
    output logic [TDESTW-1:0]          AXIS_M_TDEST,
    output logic [NUM_REQ-1:0]         GRANT,
    output logic                       BUSY,
    output logic [CNT_W-1:0]           PKT_COUNT
);
    localparam int IDXW = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t               r_state;
    logic [IDXW-1:0]      r_ptr;
    logic [IDXW-1:0]      r_gidx;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_busy;
    logic [CNT_W-1:0]     r_pkt_cnt;

    logic                 r_m_valid;
    logic [TDATAW-1:0]    r_m_data;
    logic                 r_m_last;
    logic [TDESTW-1:0]    r_m_dest;
    logic                 r_k_valid;
    logic [TDATAW-1:0]    r_k_data;
    logic                 r_k_last;
    logic [TDESTW-1:0]    r_k_dest;

    logic                 w_any_req;
    logic [IDXW-1:0]      w_win_idx;
    logic [IDXW:0]        w_cand;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [TDATAW-1:0]    w_sel_data;
    logic [TDESTW-1:0]    w_sel_dest;
    logic                 w_can_accept;
    logic                 w_push;
    logic                 w_pop;

    // Search upward from pointer+1 (wrapping) for the first requester with TVALID high.
    always_comb begin
        w_any_req = 1'b0;
        w_win_idx = {IDXW{1'b0}};
        w_cand    = {(IDXW+1){1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IDXW+1)'(k);
            if (w_cand >= (IDXW+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDXW+1)'(NUM_REQ);
            end else begin
                w_cand = w_cand;
            end
            if (!w_any_req && AXIS_S_TVALID[w_cand[IDXW-1:0]]) begin
                w_any_req = 1'b1;
                w_win_idx = w_cand[IDXW-1:0];
            end else begin
                w_any_req = w_any_req;
            end
        end
    end

    // AND-OR mux of the owner's beat; GRANT is all-zero outside LOCK so nothing leaks.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = {TDATAW{1'b0}};
        w_sel_dest  = {TDESTW{1'b0}};
        for (int r = 0; r < NUM_REQ; r++) begin
            w_sel_valid = w_sel_valid | (r_grant[r] & AXIS_S_TVALID[r]);
            w_sel_last  = w_sel_last  | (r_grant[r] & AXIS_S_TLAST[r]);
            w_sel_data  = w_sel_data  | ({TDATAW{r_grant[r]}} & AXIS_S_TDATA[r*TDATAW +: TDATAW]);
            w_sel_dest  = w_sel_dest  | ({TDESTW{r_grant[r]}} & AXIS_S_TDEST[r*TDESTW +: TDESTW]);
        end
    end

    assign w_can_accept  = ~r_k_valid;
    assign w_push        = (r_state == ST_LOCK) & w_sel_valid & w_can_accept;
    assign w_pop         = r_m_valid & AXIS_M_TREADY;
    assign AXIS_S_TREADY = r_grant & {NUM_REQ{w_can_accept}};

    // Arbitration FSM: grant in one cycle, hold the lock until the owner's TLAST is accepted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_ptr     <= IDXW'(NUM_REQ - 1);
            r_gidx    <= {IDXW{1'b0}};
            r_grant   <= {NUM_REQ{1'b0}};
            r_busy    <= 1'b0;
            r_pkt_cnt <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_LOCK;
                        r_gidx  <= w_win_idx;
                        r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (w_push && w_sel_last) begin
                        r_state   <= ST_IDLE;
                        r_ptr     <= r_gidx;
                        r_grant   <= {NUM_REQ{1'b0}};
                        r_busy    <= 1'b0;
                        r_pkt_cnt <= r_pkt_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= {NUM_REQ{1'b0}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Skid slice: main drives the output, skid catches the one beat accepted during a stall.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_m_valid <= 1'b0;
            r_m_data  <= {TDATAW{1'b0}};
            r_m_last  <= 1'b0;
            r_m_dest  <= {TDESTW{1'b0}};
            r_k_valid <= 1'b0;
            r_k_data  <= {TDATAW{1'b0}};
            r_k_last  <= 1'b0;
            r_k_dest  <= {TDESTW{1'b0}};
        end else if (r_k_valid) begin
            if (w_pop) begin
                r_m_data  <= r_k_data;
                r_m_last  <= r_k_last;
                r_m_dest  <= r_k_dest;
                r_k_valid <= 1'b0;
            end
        end else if (r_m_valid) begin
            if (w_push && w_pop) begin
                r_m_data <= w_sel_data;
                r_m_last <= w_sel_last;
                r_m_dest <= w_sel_dest;
            end else if (w_push) begin
                r_k_valid <= 1'b1;
                r_k_data  <= w_sel_data;
                r_k_last  <= w_sel_last;
                r_k_dest  <= w_sel_dest;
            end else if (w_pop) begin
                r_m_valid <= 1'b0;
            end
        end else if (w_push) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_sel_data;
            r_m_last  <= w_sel_last;
            r_m_dest  <= w_sel_dest;
        end
    end

    assign AXIS_M_TVALID = r_m_valid;
    assign AXIS_M_TDATA  = r_m_data;
    assign AXIS_M_TLAST  = r_m_last;
    assign AXIS_M_TDEST  = r_m_dest;
    assign GRANT         = r_grant;
    assign BUSY          = r_busy;
    assign PKT_COUNT     = r_pkt_cnt;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: a packet-level round-robin model predicts beat and
// grant order up front; a negedge monitor compares whatever the DUT presents.
module tb_axis_rr_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] dest;
        logic          last;
    } beat_t;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b1;
    logic [NR-1:0]     s_valid;
    logic [NR-1:0]     s_ready;
    logic [NR*DW-1:0]  s_data;
    logic [NR-1:0]     s_last;
    logic [NR*SW-1:0]  s_dest;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic              m_last;
    logic [SW-1:0]     m_dest;
    logic [NR-1:0]     grant;
    logic              busy;
    logic [CW-1:0]     pkt_count;

    int    checks = 0;
    int    errors = 0;
    int    gcyc = 0;
    int    seq = 0;
    int    exp_pkts = 0;
    int    first_mv_g = -1;
    int    stall_acc = 0;
    bit    stall_ready_low = 1'b0;
    beat_t req_q [NR][$];
    beat_t exp_q [$];
    int    exp_grant_q [$];
    int    out_g [$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) gcyc <= gcyc + 1;

    axis_rr_arbiter #(.TDATAW(DW), .TDESTW(SW), .NUM_REQ(NR), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .AXIS_S_TVALID(s_valid), .AXIS_S_TREADY(s_ready), .AXIS_S_TDATA(s_data),
        .AXIS_S_TLAST(s_last), .AXIS_S_TDEST(s_dest),
        .AXIS_M_TVALID(m_valid), .AXIS_M_TREADY(m_ready), .AXIS_M_TDATA(m_data),
        .AXIS_M_TLAST(m_last), .AXIS_M_TDEST(m_dest),
        .GRANT(grant), .BUSY(busy), .PKT_COUNT(pkt_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, stall stability, grant order and owner-only TREADY.
    logic [NR-1:0] prev_grant = '0;
    bit            prev_stall = 1'b0;
    beat_t         prev_beat;
    beat_t         mon_e;
    int            mon_g;
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_grant = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", 64'(m_valid), 64'd1);
                check("stall_payload_hold", 64'({m_data, m_dest, m_last}), 64'(prev_beat));
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_data, m_dest, m_last};
            if (m_valid && first_mv_g < 0) first_mv_g = gcyc;
            if (m_valid && m_ready) begin
                out_g.push_back(gcyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_beat: got unexpected beat 0x%0h, expected none", m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_beat", 64'({m_data, m_dest, m_last}), 64'(mon_e));
                end
            end
            if (grant != '0 && prev_grant == '0) begin
                if (exp_grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_order: got grant 0x%0h, expected none", grant);
                end else begin
                    mon_g = exp_grant_q.pop_front();
                    check("grant_order", 64'(grant), 64'(1) << mon_g);
                end
            end
            check("tready_only_owner", 64'(s_ready & ~grant), 64'd0);
            check("busy_vs_grant", 64'(busy), 64'(grant != '0));
            prev_grant = grant;
        end
    end

    task automatic add_beat(input int r, input logic [DW-1:0] d, input logic [SW-1:0] t, input logic l);
        beat_t b;
        b.data = d;
        b.dest = t;
        b.last = l;
        req_q[r].push_back(b);
    endtask

    task automatic add_rand_pkt(input int r, input int len);
        logic [SW-1:0] t;
        t = SW'($urandom_range(15));
        for (int i = 0; i < len; i++)
            add_beat(r, {8'(r), 8'(seq), 16'($urandom)}, t, i == len - 1);
        seq++;
    endtask

    // Reference: whenever the port is free, the next packet comes from the first requester
    // with packets left, searching upward from the previous winner (requester 0 after reset).
    task automatic build_expected(output int npk);
        int p [NR];
        int ptr;
        int pick;
        ptr = NR - 1;
        npk = 0;
        for (int r = 0; r < NR; r++) p[r] = 0;
        pick = 0;
        while (pick >= 0) begin
            pick = -1;
            for (int k = 1; k <= NR; k++)
                if (pick < 0 && p[(ptr + k) % NR] < req_q[(ptr + k) % NR].size()) pick = (ptr + k) % NR;
            if (pick >= 0) begin
                exp_grant_q.push_back(pick);
                do begin
                    exp_q.push_back(req_q[pick][p[pick]]);
                    p[pick]++;
                end while (!req_q[pick][p[pick]-1].last);
                ptr = pick;
                npk++;
            end
        end
    endtask

    // Requester and sink driver; first beat of every packet is presented with TVALID high.
    task automatic drive(input int budget, input bit bubbles, input bit rand_ready,
                         input int stall_at, input int stall_len, input int start1, input int abort_at);
        int    pos [NR];
        bit    acc [NR];
        int    cyc;
        bit    done;
        bit    first;
        beat_t b;
        cyc = 0;
        done = 1'b0;
        for (int r = 0; r < NR; r++) begin
            pos[r] = 0;
            acc[r] = 1'b0;
        end
        while (1) begin
            for (int r = 0; r < NR; r++) begin
                if (acc[r]) pos[r]++;
                if (acc[r] || !s_valid[r]) begin
                    if (pos[r] < req_q[r].size() && !(r == 1 && cyc < start1)) begin
                        b = req_q[r][pos[r]];
                        s_data[r*DW +: DW] = b.data;
                        s_dest[r*SW +: SW] = b.dest;
                        s_last[r] = b.last;
                        first = (pos[r] == 0) || req_q[r][pos[r]-1].last;
                        s_valid[r] = (first || !bubbles) ? 1'b1 : ($urandom_range(3) != 0);
                    end else begin
                        s_valid[r] = 1'b0;
                    end
                end
            end
            if (cyc >= stall_at && cyc < stall_at + stall_len) m_ready = 1'b0;
            else m_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
            done = (exp_q.size() == 0);
            for (int r = 0; r < NR; r++) if (pos[r] < req_q[r].size()) done = 1'b0;
            if (done || cyc >= budget || cyc == abort_at) break;
            @(negedge CLK);
            for (int r = 0; r < NR; r++) acc[r] = s_valid[r] & s_ready[r];
            if (cyc >= stall_at && cyc < stall_at + stall_len) begin
                for (int r = 0; r < NR; r++) if (acc[r]) stall_acc++;
                if (cyc == stall_at + stall_len - 1) stall_ready_low = (s_ready == '0);
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        s_valid = '0;
        m_ready = 1'b1;
        if (abort_at < 0 && !done) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: got %0d beats outstanding after %0d cycles, expected 0", exp_q.size(), cyc);
        end
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before any clock edge.
    task automatic apply_reset();
        s_valid = '0;
        m_ready = 1'b1;
        #3;
        RST_N = 1'b0;
        #1;
        check("reset_outputs_zero",
              64'({m_valid, m_data, m_last, m_dest, grant, busy, pkt_count, s_ready}), 64'd0);
        exp_q.delete();
        exp_grant_q.delete();
        out_g.delete();
        for (int r = 0; r < NR; r++) req_q[r].delete();
        exp_pkts = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic finish_phase(input string name, input int npk);
        exp_pkts += npk;
        check({name, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkts % (1 << CW)));
        check({name, "_grant_idle"}, 64'(grant), 64'd0);
        check({name, "_grants_left"}, 64'(exp_grant_q.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npk;
        int start_g;
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
        s_dest  = '0;
        m_ready = 1'b1;
        apply_reset();

        // Single requester, 3 beats, latency 2 cycles.
        add_beat(0, 32'h11, 4'd1, 1'b0);
        add_beat(0, 32'h22, 4'd1, 1'b0);
        add_beat(0, 32'h33, 4'd1, 1'b1);
        build_expected(npk);
        start_g = gcyc;
        first_mv_g = -1;
        drive(200, 1'b0, 1'b0, -1, 0, 0, -1);
        check("single_latency", 64'(first_mv_g - start_g), 64'd2);
        finish_phase("single", npk);

        // Simultaneous requests: req0 first, one idle output cycle, then req1.
        apply_reset();
        add_rand_pkt(0, 2);
        add_rand_pkt(1, 2);
        build_expected(npk);
        drive(200, 1'b0, 1'b0, -1, 0, 0, -1);
        check("simul_beats", 64'(out_g.size()), 64'd4);
        if (out_g.size() == 4) begin
            check("simul_pkt0_contig", 64'(out_g[1] - out_g[0]), 64'd1);
            check("simul_one_bubble", 64'(out_g[2] - out_g[1]), 64'd2);
            check("simul_pkt1_contig", 64'(out_g[3] - out_g[2]), 64'd1);
        end
        finish_phase("simul", npk);

        // Fairness: 1-beat packets, both requesters always pending.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            add_rand_pkt(0, 1);
            add_rand_pkt(1, 1);
        end
        build_expected(npk);
        drive(300, 1'b0, 1'b0, -1, 0, 0, -1);
        finish_phase("fair", npk);

        // Backpressure: 5-cycle stall during a 4-beat packet.
        apply_reset();
        add_rand_pkt(0, 4);
        build_expected(npk);
        stall_acc = 0;
        stall_ready_low = 1'b0;
        drive(300, 1'b0, 1'b0, 3, 5, 0, -1);
        check("bp_accepts_le2", 64'(stall_acc <= 2), 64'd1);
        check("bp_tready_low", 64'(stall_ready_low), 64'd1);
        finish_phase("bp", npk);

        // No interleave: req1 rises mid-packet of req0, bubbles and random backpressure.
        apply_reset();
        add_rand_pkt(0, 5);
        add_rand_pkt(1, 2);
        build_expected(npk);
        drive(400, 1'b1, 1'b1, -1, 0, 3, -1);
        finish_phase("nointl", npk);

        // Counter wrap: 16 random packets bring a 4-bit counter back to 0.
        apply_reset();
        for (int i = 0; i < 16; i++) add_rand_pkt(int'($urandom_range(1)), int'($urandom_range(1, 3)));
        build_expected(npk);
        drive(3000, 1'b1, 1'b1, -1, 0, 0, -1);
        finish_phase("wrap", npk);
        check("wrap_to_zero", 64'(pkt_count), 64'd0);

        // Reset mid-packet, then traffic must recover cleanly.
        apply_reset();
        add_rand_pkt(0, 6);
        add_rand_pkt(1, 2);
        build_expected(npk);
        drive(100, 1'b0, 1'b0, -1, 0, 0, 4);
        check("midpkt_busy", 64'(busy), 64'd1);
        apply_reset();
        for (int i = 0; i < 6; i++) add_rand_pkt(int'($urandom_range(1)), int'($urandom_range(1, 4)));
        build_expected(npk);
        drive(2000, 1'b1, 1'b1, -1, 0, 0, -1);
        finish_phase("recover", npk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
